// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline-control slice: register bus macros,
// data-memory wait FSM states and the hazard classes used for resolution.
`ifndef RISCV_DEFINE_SVH
`define RISCV_DEFINE_SVH
`define RegBus     31:0
`define RegAddrBus 4:0
`endif

package riscv_pipe_ctrl_pkg;

  // Data-memory wait FSM states
  typedef enum logic [0:0] {
    DM_IDLE = 1'b0,
    DM_WAIT = 1'b1
  } dm_state_t;

  // Hazard classes, listed from lowest to highest priority
  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_IFETCH   = 3'd1,
    HZ_LOAD_USE = 3'd2,
    HZ_BRANCH   = 3'd3,
    HZ_DMEM     = 3'd4
  } hazard_t;

  // Picks the single hazard that wins the priority D > B > L > I
  function automatic hazard_t pick_hazard(input logic d, input logic b,
                                          input logic l, input logic i);
    hazard_t h;
    if (d)      h = HZ_DMEM;
    else if (b) h = HZ_BRANCH;
    else if (l) h = HZ_LOAD_USE;
    else if (i) h = HZ_IFETCH;
    else        h = HZ_NONE;
    return h;
  endfunction

endpackage

// File: rtl/riscv_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently in EX. Purely combinational.
import riscv_pipe_ctrl_pkg::*;

module riscv_hazard_detect (
  input  logic             ex_MemtoReg,
  input  logic             ex_RegWr,
  input  logic [`RegAddrBus] ex_rd_idx,
  input  logic [`RegAddrBus] id_rs1_idx,
  input  logic [`RegAddrBus] id_rs2_idx,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  output logic             load_use
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired zero, so a load "into" it never produces a hazard
  always_comb begin
    ex_is_load = ex_MemtoReg && ex_RegWr && (ex_rd_idx != '0);
    rs1_hit    = id_rs1_used && (id_rs1_idx == ex_rd_idx);
    rs2_hit    = id_rs2_used && (id_rs2_idx == ex_rd_idx);
    load_use   = ex_is_load && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Central hazard / pipeline-control unit for the 5-stage core: resolves
// dmem wait, branch redirect, load-use and ifetch wait into per-register
// stall/flush controls, runs the dmem wait watchdog and perf counters.
import riscv_pipe_ctrl_pkg::*;

module riscv_pipe_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [`RegAddrBus] id_rs1_idx,
  input  logic [`RegAddrBus] id_rs2_idx,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic               ex_MemtoReg,
  input  logic               ex_RegWr,
  input  logic [`RegAddrBus] ex_rd_idx,
  input  logic               ex_branch_taken,
  input  logic               mem_access,
  input  logic               dmem_ready,
  input  logic               imem_ready,
  output logic               pc_stall,
  output logic               if_id_stall,
  output logic               if_id_flush,
  output logic               id_ex_stall,
  output logic               id_ex_flush,
  output logic               ex_mem_stall,
  output logic               ex_mem_flush,
  output logic               mem_wb_stall,
  output logic               mem_wb_flush,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int                 WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  dm_state_t         state;
  dm_state_t         state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              dmem_wait;
  logic              load_use;
  hazard_t           hazard;
  logic              any_flush;

  riscv_hazard_detect u_hazard_detect (
    .ex_MemtoReg (ex_MemtoReg),
    .ex_RegWr    (ex_RegWr),
    .ex_rd_idx   (ex_rd_idx),
    .id_rs1_idx  (id_rs1_idx),
    .id_rs2_idx  (id_rs2_idx),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .load_use    (load_use)
  );

  // Classify the current cycle; a dmem ready in the same cycle as the
  // access means no wait at all
  always_comb begin
    dmem_wait = mem_access && !dmem_ready;
    hazard    = pick_hazard(dmem_wait, ex_branch_taken, load_use, !imem_ready);
  end

  // FSM state register; reset abandons any wait in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DM_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // FSM next state and wait counter; the counter sticks at TIMEOUT
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      DM_IDLE: begin
        if (dmem_wait) begin
          state_next    = DM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      DM_WAIT: begin
        if (dmem_wait) begin
          if (wait_cnt != WAIT_MAX) wait_cnt_next = wait_cnt + WAIT_W'(1);
        end else begin
          state_next    = DM_IDLE;
          wait_cnt_next = '0;
        end
      end
      default: begin
        state_next    = DM_IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Output decode: only the winning hazard drives the pipeline registers
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst) begin
      case (hazard)
        HZ_DMEM: begin
          // Freeze everything up to MEM, bubble into WB; a taken branch in EX
          // stays held there and gets serviced once the access completes
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
        end
        HZ_BRANCH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        HZ_LOAD_USE: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        HZ_IFETCH: begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky watchdog: set on the edge where the wait count reaches TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mem_timeout <= 1'b0;
    else if (dmem_wait && (wait_cnt_next == WAIT_MAX))
      mem_timeout <= 1'b1;
  end

  assign any_flush = if_id_flush || id_ex_flush || ex_mem_flush || mem_wb_flush;

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (any_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Self-checking bench for riscv_pipe_ctrl: a behavioural model predicts the
// control outputs, watchdog and counters every cycle; directed scenarios add
// hand-computed literal checks.
module tb_riscv_pipe_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 5;
  localparam int CMAX    = 31;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic             id_rs1_used, id_rs2_used;
  logic             ex_MemtoReg, ex_RegWr, ex_branch_taken;
  logic             mem_access, dmem_ready, imem_ready;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic             ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_wait  = 0;
  bit m_to    = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  riscv_pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_MemtoReg(ex_MemtoReg), .ex_RegWr(ex_RegWr), .ex_rd_idx(ex_rd_idx),
    .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic cmp(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Expected control word {pc, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, memwb_f}
  function automatic logic [8:0] expect_ctl();
    bit lu;
    lu = ex_MemtoReg && ex_RegWr && (ex_rd_idx != 0) &&
         ((id_rs1_used && id_rs1_idx == ex_rd_idx) || (id_rs2_used && id_rs2_idx == ex_rd_idx));
    if (rst)                          return 9'b000000000;
    if (mem_access && !dmem_ready)    return 9'b110101001;
    if (ex_branch_taken)              return 9'b001010000;
    if (lu)                           return 9'b110010000;
    if (!imem_ready)                  return 9'b101000000;
    return 9'b000000000;
  endfunction

  function automatic logic [8:0] dut_ctl();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
            ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush};
  endfunction

  // Model advance: counts consecutive wait cycles and events per clock
  always @(posedge clk or posedge rst) begin
    logic [8:0] e;
    if (rst) begin
      m_wait = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      e = expect_ctl();
      if (e[8] && m_stall < CMAX) m_stall++;
      if ((e[6] || e[4] || e[2] || e[0]) && m_flush < CMAX) m_flush++;
      if (mem_access && !dmem_ready) begin
        m_wait++;
        if (m_wait >= TIMEOUT) m_to = 1'b1;
      end else begin
        m_wait = 0;
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge
  always @(negedge clk) begin
    cmp("ctl", dut_ctl(), expect_ctl());
    cmp("mem_timeout", mem_timeout, m_to);
    cmp("stall_cnt", stall_cnt, m_stall);
    cmp("flush_cnt", flush_cnt, m_flush);
  end

  task automatic idle();
    id_rs1_idx = 0; id_rs2_idx = 0; ex_rd_idx = 0;
    id_rs1_used = 0; id_rs2_used = 0;
    ex_MemtoReg = 0; ex_RegWr = 0; ex_branch_taken = 0;
    mem_access = 0; dmem_ready = 0; imem_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_to(input logic [4:0] rd);
    ex_MemtoReg = 1; ex_RegWr = 1; ex_rd_idx = rd;
  endtask

  initial begin
    idle();
    step(); step();
    cmp("rst_stall_cnt", stall_cnt, 0);
    cmp("rst_ctl", dut_ctl(), 0);
    rst = 1'b0;
    step();

    // load-use on rs1 = x5
    load_to(5); id_rs1_idx = 5; id_rs1_used = 1;
    #2 cmp("lu_pc_stall", pc_stall, 1); cmp("lu_if_id_stall", if_id_stall, 1);
    cmp("lu_id_ex_flush", id_ex_flush, 1);
    step(); idle();
    #2 cmp("lu_release", pc_stall, 0);
    cmp("lu_stall_cnt", stall_cnt, 1); cmp("lu_flush_cnt", flush_cnt, 1);

    // load into x0 never stalls
    step(); load_to(0); id_rs1_idx = 0; id_rs1_used = 1;
    #2 cmp("x0_ctl", dut_ctl(), 0);

    // rs2 match only counts when rs2 is read
    step(); idle(); load_to(7); id_rs1_idx = 3; id_rs1_used = 1; id_rs2_idx = 7;
    #2 cmp("rs2_unused", pc_stall, 0);
    step(); id_rs2_used = 1;
    #2 cmp("rs2_used", pc_stall, 1);
    step(); idle();
    #2 cmp("rs2_stall_cnt", stall_cnt, 2);

    // taken branch for one cycle
    ex_branch_taken = 1;
    #2 cmp("br_ctl", dut_ctl(), 9'b001010000);
    step(); idle();
    #2 cmp("br_flush_cnt", flush_cnt, 3);

    // ifetch wait, 2 cycles
    imem_ready = 0;
    #2 cmp("if_ctl", dut_ctl(), 9'b101000000);
    step(); step(); idle();
    #2 cmp("if_stall_cnt", stall_cnt, 4);

    // dmem wait 3 cycles then ready
    mem_access = 1; dmem_ready = 0;
    #2 cmp("dm_ctl", dut_ctl(), 9'b110101001);
    step(); step(); step();
    dmem_ready = 1;
    #2 cmp("dm_done_ctl", dut_ctl(), 0);
    step(); idle();
    #2 cmp("dm_stall_cnt", stall_cnt, 7); cmp("dm_flush_cnt", flush_cnt, 8);

    // simultaneous D + B + L: only D responds, branch serviced after ready
    mem_access = 1; dmem_ready = 0; ex_branch_taken = 1;
    load_to(9); id_rs2_idx = 9; id_rs2_used = 1;
    #2 cmp("dbl_ctl", dut_ctl(), 9'b110101001);
    step(); step();
    dmem_ready = 1;
    #2 cmp("dbl_branch_ctl", dut_ctl(), 9'b001010000);
    step(); idle();
    #2 cmp("dbl_stall_cnt", stall_cnt, 9); cmp("dbl_flush_cnt", flush_cnt, 11);

    // dmem ready together with access: no stall
    mem_access = 1; dmem_ready = 1;
    #2 cmp("same_cycle_ctl", dut_ctl(), 0);
    step(); idle();

    // watchdog: ready held low for 6 cycles
    mem_access = 1; dmem_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      #2 cmp("wd_timeout", mem_timeout, (k >= 5) ? 1 : 0);
      step();
    end
    cmp("wd_sticky", mem_timeout, 1);
    cmp("wd_stall_cnt", stall_cnt, 15);

    // async reset pulse mid-wait
    #1 rst = 1'b1;
    #1 cmp("rst_timeout", mem_timeout, 0); cmp("rst_stall", stall_cnt, 0);
    cmp("rst_flush", flush_cnt, 0); cmp("rst_ctl_forced", dut_ctl(), 0);
    rst = 1'b0;
    step(); idle();
    #2 cmp("post_rst_timeout", mem_timeout, 0); cmp("post_rst_stall", stall_cnt, 1);

    // counter saturation
    imem_ready = 0;
    for (int k = 0; k < 40; k++) step();
    idle();
    #2 cmp("sat_stall_cnt", stall_cnt, CMAX); cmp("sat_flush_cnt", flush_cnt, CMAX);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
